// File: rtl/ram_rib_bsel.sv
// RIB bus RAM slave: byte-lane writes, fixed 1- or 2-cycle request-to-ack
// pipeline, optional out-of-range error reporting.
module ram_rib_bsel #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1,
   parameter int ERR_EN = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [DATA_W/8-1:0] sel_i,
   output logic [DATA_W-1:0]   data_o,
   output logic                ack_o,
   output logic                err_o
);

   localparam int LANES = DATA_W / 8;
   localparam int OFS   = $clog2(LANES);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TOP   = OFS + IDX_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              oor;
   logic              wr_en;
   logic              addr_unused;

   assign idx = addr_i[OFS +: IDX_W];
   // Byte-offset bits (and upper bits when wrapping) are intentionally ignored.
   assign addr_unused = ^addr_i;

   generate
      if (ERR_EN != 0 && TOP < ADDR_W) begin : g_err
         assign oor = |addr_i[ADDR_W-1:TOP];
      end else begin : g_noerr
         assign oor = 1'b0;
      end
   endgenerate

   // Acceptance requires rst high at the edge, so gate the write with it.
   assign wr_en = req_i & we_i & ~oor & rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int n = 0; n < LANES; n++) begin
            if (sel_i[n]) mem[idx][8*n +: 8] <= data_i[8*n +: 8];
         end
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         // p0 -> output: memory sampled straight into data_o at acceptance
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ack_o  <= 1'b0;
               err_o  <= 1'b0;
               data_o <= '0;
            end else begin
               ack_o <= req_i;
               err_o <= req_i & oor;
               if (req_i && !we_i) data_o <= oor ? '0 : mem[idx];
            end
         end
      end else begin : g_lat2
         logic              vld_p0;
         logic              rd_p0;
         logic              err_p0;
         logic [DATA_W-1:0] rdata_p0;
         logic              rd_en;

         assign rd_en = req_i & ~we_i & rst;

         // p0: control state of the accepted request
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_p0 <= 1'b0;
               rd_p0  <= 1'b0;
               err_p0 <= 1'b0;
            end else begin
               vld_p0 <= req_i;
               rd_p0  <= req_i & ~we_i;
               err_p0 <= req_i & oor;
            end
         end

         // p0: plain synchronous RAM read port, no reset so it maps to block RAM
         always_ff @(posedge clk) begin
            if (rd_en) rdata_p0 <= mem[idx];
         end

         // p0 -> output
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ack_o  <= 1'b0;
               err_o  <= 1'b0;
               data_o <= '0;
            end else begin
               ack_o <= vld_p0;
               err_o <= vld_p0 & err_p0;
               if (vld_p0 && rd_p0) data_o <= err_p0 ? '0 : rdata_p0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ram_rib_bsel.sv
// Directed bench for ram_rib_bsel: three instances (latency 1, latency 2,
// wrap mode) driven by one shared request stream.
module tb_ram_rib_bsel;

   logic        clk;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  sel;

   logic [31:0] d1, d2, dn;
   logic        a1, a2, an;
   logic        e1, e2, en;

   int n_chk;
   int n_err;

   ram_rib_bsel #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(1), .ERR_EN(1)) u_l1 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
      .sel_i(sel), .data_o(d1), .ack_o(a1), .err_o(e1));

   ram_rib_bsel #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(2), .ERR_EN(1)) u_l2 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
      .sel_i(sel), .data_o(d2), .ack_o(a2), .err_o(e2));

   ram_rib_bsel #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(1), .ERR_EN(0)) u_ne (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
      .sel_i(sel), .data_o(dn), .ack_o(an), .err_o(en));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      req   = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      sel   = s;
   endtask

   task automatic idle();
      req = 1'b0;
      we  = 1'b0;
      sel = 4'h0;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      clk   = 1'b0;
      rst   = 1'b1;
      addr  = '0;
      wdata = '0;
      idle();
      #2 rst = 1'b0;
      tick();
      tick();
      check("rst_ack_l1", {31'd0, a1}, 32'd0);
      check("rst_err_l1", {31'd0, e1}, 32'd0);
      check("rst_data_l1", d1, 32'd0);
      check("rst_ack_l2", {31'd0, a2}, 32'd0);
      check("rst_data_l2", d2, 32'd0);
      check("rst_ack_ne", {31'd0, an}, 32'd0);
      rst = 1'b1;

      // byte-lane write then read
      drive(1'b1, 32'h8, 32'h11223344, 4'hF); tick();
      drive(1'b1, 32'h8, 32'hAABBCCDD, 4'h5); tick();
      drive(1'b0, 32'h8, 32'h0, 4'h0);        tick();
      check("bl_l1_ack", {31'd0, a1}, 32'd1);
      check("bl_l1_data", d1, 32'h11BB33DD);
      check("bl_l1_err", {31'd0, e1}, 32'd0);
      idle(); tick();
      check("bl_l2_ack", {31'd0, a2}, 32'd1);
      check("bl_l2_data", d2, 32'h11BB33DD);
      check("bl_l1_pulse", {31'd0, a1}, 32'd0);
      tick(); tick();

      // preload and pipelined reads
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
         tick();
      end
      idle(); tick(); tick();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b0, 32'(i * 4), 32'h0, 4'h0);
         else idle();
         tick();
         check($sformatf("pipe_ack_%0d", i), {31'd0, a2}, (i >= 1 && i <= 4) ? 32'd1 : 32'd0);
         if (i >= 1 && i <= 4) check($sformatf("pipe_data_%0d", i), d2, 32'hA0 + 32'(i - 1));
      end

      // read-after-write
      drive(1'b1, 32'h4, 32'hDEADBEEF, 4'hF); tick();
      check("raw_l1_wack", {31'd0, a1}, 32'd1);
      drive(1'b0, 32'h4, 32'h0, 4'h0); tick();
      check("raw_l1_data", d1, 32'hDEADBEEF);
      check("raw_l2_wack", {31'd0, a2}, 32'd1);
      check("raw_l2_hold", d2, 32'hA3);
      idle(); tick();
      check("raw_l2_rack", {31'd0, a2}, 32'd1);
      check("raw_l2_data", d2, 32'hDEADBEEF);
      tick();

      // out of range
      drive(1'b1, 32'h40, 32'h12345678, 4'hF); tick();
      check("oor_l1_wack", {31'd0, a1}, 32'd1);
      check("oor_l1_werr", {31'd0, e1}, 32'd1);
      check("oor_ne_werr", {31'd0, en}, 32'd0);
      drive(1'b0, 32'h40, 32'h0, 4'h0); tick();
      check("oor_l1_rerr", {31'd0, e1}, 32'd1);
      check("oor_l1_rdata", d1, 32'h0);
      check("oor_l2_werr", {31'd0, e2}, 32'd1);
      check("oor_ne_rdata", dn, 32'h12345678);
      check("oor_ne_rerr", {31'd0, en}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
      check("oor_l1_word0", d1, 32'hA0);
      check("oor_l1_err0", {31'd0, e1}, 32'd0);
      check("oor_l2_rerr", {31'd0, e2}, 32'd1);
      check("oor_l2_rdata", d2, 32'h0);
      idle(); tick();
      check("oor_l2_word0", d2, 32'hA0);
      check("idle_l1_err", {31'd0, e1}, 32'd0);
      check("idle_l1_ack", {31'd0, a1}, 32'd0);
      tick();

      // hold through writes and zero strobe
      drive(1'b0, 32'h0, 32'h0, 4'h0);        tick();
      drive(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0); tick();
      check("hz_l1_rd", d1, 32'hA0);
      drive(1'b0, 32'h0, 32'h0, 4'h0);        tick();
      check("hz_l1_wack", {31'd0, a1}, 32'd1);
      check("hz_l1_hold", d1, 32'hA0);
      idle(); tick();
      check("hz_l1_rd2", d1, 32'hA0);
      check("hz_l2_wack", {31'd0, a2}, 32'd1);
      check("hz_l2_hold", d2, 32'hA0);
      tick();
      check("hz_l2_rd2", d2, 32'hA0);
      tick();

      // reset mid-flight
      drive(1'b0, 32'h4, 32'h0, 4'h0); tick();
      rst = 1'b0;
      idle();
      #1;
      check("rs_l2_ack", {31'd0, a2}, 32'd0);
      check("rs_l2_err", {31'd0, e2}, 32'd0);
      check("rs_l2_data", d2, 32'h0);
      check("rs_l1_ack", {31'd0, a1}, 32'd0);
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rs_noack_%0d", i), {31'd0, a2}, 32'd0);
      end
      drive(1'b0, 32'h4, 32'h0, 4'h0); tick();
      idle(); tick();
      check("rs_after_ack", {31'd0, a2}, 32'd1);
      check("rs_after_data", d2, 32'hDEADBEEF);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ram_rib_bsel.md
Name: ram_rib_bsel

Overview:
- Parametrised on-chip RAM slave for the RIB bus: the next-generation data/instruction RAM.
- Adds byte-lane write strobes, configurable word width and depth, and a registered fixed-latency read pipeline with an explicit ack.
- Adds out-of-range error signalling.
- Sits behind the RIB interconnect as a slave, serving core load/store and JTAG/debug accesses.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8 and at least 8.
- DEPTH, 4096: number of words; must be a power of 2.
- ADDR_W, 32: byte-address width of addr_i.
- RD_LAT, 1: request-to-ack latency in cycles; legal values 1 or 2. Applies to reads and writes.
- ERR_EN, 1: 1 = detect out-of-range addresses; 0 = silently wrap (upper bits ignored).

Ports:
- clk, input, 1: clock; all state on rising edge.
- rst, input, 1: asynchronous active-low reset.
- req_i, input, 1: request valid; one request accepted per cycle, no backpressure.
- we_i, input, 1: 1 = write, 0 = read; qualified by req_i.
- addr_i, input, ADDR_W: byte address.
- data_i, input, DATA_W: write data.
- sel_i, input, DATA_W/8: byte-lane write enables; bit n covers data bits [8n+7:8n].
- data_o, output, DATA_W: registered read data.
- ack_o, output, 1: one-cycle completion pulse per accepted request.
- err_o, output, 1: qualifies ack_o; 1 = the request was out of range.

Behaviour:
- Address decode: OFS = log2(DATA_W/8); word index = addr_i[OFS +: log2(DEPTH)]. Low OFS bits are ignored (no misalignment error).
- Out of range: any addr_i bit at or above OFS + log2(DEPTH) is nonzero and ERR_EN = 1.
- Acceptance: req_i = 1 at a rising edge with rst high. Every such cycle is an independent transaction; back-to-back requests are fully pipelined.
- Write, in range: at the acceptance edge, each byte lane with sel_i[n] = 1 takes data_i; other lanes are unchanged. sel_i = 0 changes nothing and is still acked.
- Write, out of range: the array is unmodified.
- Read: the array is sampled at the acceptance edge, so it reflects every write accepted in earlier cycles (read-after-write to the same word in the next cycle returns the new data at both latencies).
- RD_LAT = 1: the sampled word drives data_o and ack_o pulses in the cycle after acceptance.
- RD_LAT = 2: one extra register stage; ack_o and data_o appear 2 cycles after acceptance.
- Completion order equals acceptance order; reads and writes share the same pipeline.
- ack_o is high for exactly one cycle per accepted request. Back-to-back requests give back-to-back ack cycles.
- err_o is valid only while ack_o = 1; otherwise it is 0.
- data_o update rules:
  - Updates only on a read ack.
  - Holds its previous value through write acks and idle cycles.
  - An out-of-range read acks with data_o = 0 and err_o = 1.
- ERR_EN = 0: err_o is tied 0 and out-of-range addresses alias modulo DEPTH.
- Reset (rst low, asynchronous):
  - ack_o = 0, err_o = 0, data_o = 0.
  - All pipeline valid bits are cleared.
  - Memory contents are NOT reset or initialised.
- Reset mid-operation: in-flight acks are dropped and never produced. A write whose acceptance edge already occurred stays committed.
- First acceptance possible: the first rising edge after rst deasserts.
- Storage is a single-port array (one access per cycle), inferable as block RAM for RD_LAT = 2.

Test Plan:
- Byte-lane write (DATA_W=32, DEPTH=16, RD_LAT=1): write 0x11223344 to 0x8 with sel=0xF, then 0xAABBCCDD with sel=0x5, then read 0x8 -> ack 1 cycle after the read request, data_o = 0x11BB33DD, err_o = 0.
- Pipelining (RD_LAT=2): preload words 0..3 with 0xA0..0xA3; issue 4 consecutive reads at 0x0, 0x4, 0x8, 0xC -> 4 consecutive ack cycles starting 2 cycles after the first request, data_o = 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Read-after-write (RD_LAT=1 and 2): write 0xDEADBEEF to 0x4 in cycle N, read 0x4 in cycle N+1 -> the read ack returns 0xDEADBEEF. The write ack precedes the read ack by exactly 1 cycle.
- Out of range (ERR_EN=1, DEPTH=16): write 0x12345678 to 0x40, then read 0x40 -> both acks have err_o = 1 and the read returns data_o = 0. Word 0 is unchanged (read 0x0 still returns its preload). With ERR_EN=0, the same read returns word 0 and err_o = 0.
- Reset mid-flight (RD_LAT=2): issue a read, assert rst low 1 cycle later -> ack_o, err_o and data_o go 0 immediately. No ack appears after release. A prior completed write is still readable afterwards.
- Hold and zero-strobe: read 0x0 (0xA0), then write 0x0 with sel=0x0 and data 0xFFFFFFFF -> the write acks, data_o stays 0xA0, and a subsequent read of 0x0 returns 0xA0.
